// File: rtl/spi_aes_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_aes_master_ctrl
//  Purpose  : SPI master (mode 0) that sends {cmd, key, block} on MOSI, waits
//             a turnaround gap, then shifts a 128-bit AES result in on MISO.
//  Options  : SPI_CTRL_KEY_REUSE_EN - skip the key when it matches the key of
//             the last completed transfer (136-bit frame instead of 264).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_aes_master_ctrl #(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         decrypt,
   input  logic [127:0] key,
   input  logic [127:0] data_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out,
   output logic         sclk,
   output logic         mosi,
   input  logic         miso,
   output logic         CS
);

   localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
   localparam logic [9:0] GAP_LAST = 10'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHIFT_OUT = 3'd1,
      S_GAP       = 3'd2,
      S_SHIFT_IN  = 3'd3,
      S_CS_HOLD   = 3'd4
   } state_t;

   state_t         state_q;
   logic [263:0]   tx_q;
   logic [127:0]   rx_q;
   logic [127:0]   data_out_q;
   logic [8:0]     bit_q;
   logic [8:0]     bit_last_q;
   logic [7:0]     ph_q;
   logic [9:0]     gap_q;
   logic           sclk_q;
   logic           mosi_q;
   logic           cs_q;
   logic           busy_q;
   logic           done_q;

   logic           key_hit_d;
   logic [7:0]     cmd_d;
   logic           cmpl_d;

   // Transfer completes on the last cycle of the CS hold phase
   assign cmpl_d = (state_q == S_CS_HOLD) && (ph_q == PH_LAST);

`ifdef SPI_CTRL_KEY_REUSE_EN
   logic [127:0]   key_q;
   logic [127:0]   last_key_q;
   logic           key_vld_q;

   assign key_hit_d = key_vld_q && (key == last_key_q);

   // Key cache: remember the key of the transfer in flight, commit it on completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q      <= '0;
         last_key_q <= '0;
         key_vld_q  <= 1'b0;
      end else begin
         if (state_q == S_IDLE && start) begin
            key_q <= key;
         end
         if (cmpl_d) begin
            last_key_q <= key_q;
            key_vld_q  <= 1'b1;
         end
      end
   end
`else
   assign key_hit_d = 1'b0;
`endif

   assign cmd_d = {6'b101001, ~key_hit_d, decrypt};

   // Main sequencer: frame out, gap, frame in, CS hold, with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tx_q       <= '0;
         rx_q       <= '0;
         data_out_q <= '0;
         bit_q      <= '0;
         bit_last_q <= '0;
         ph_q       <= '0;
         gap_q      <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  // Frame is left-aligned so the MSB always leaves first
                  tx_q       <= key_hit_d ? {cmd_d, data_in, 128'd0} : {cmd_d, key, data_in};
                  bit_last_q <= key_hit_d ? 9'd135 : 9'd263;
                  mosi_q     <= cmd_d[7];
                  bit_q      <= '0;
                  ph_q       <= '0;
                  sclk_q     <= 1'b0;
                  cs_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_SHIFT_OUT;
               end
            end
            S_SHIFT_OUT: begin
               if (ph_q == PH_LAST) begin
                  ph_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // Falling edge: advance to the next bit
                     sclk_q <= 1'b0;
                     tx_q   <= {tx_q[262:0], 1'b0};
                     if (bit_q == bit_last_q) begin
                        mosi_q  <= 1'b0;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                     end else begin
                        mosi_q <= tx_q[262];
                        bit_q  <= bit_q + 9'd1;
                     end
                  end
               end else begin
                  ph_q <= ph_q + 8'd1;
               end
            end
            S_GAP: begin
               if (gap_q == GAP_LAST) begin
                  ph_q    <= '0;
                  bit_q   <= '0;
                  state_q <= S_SHIFT_IN;
               end else begin
                  gap_q <= gap_q + 10'd1;
               end
            end
            S_SHIFT_IN: begin
               if (ph_q == PH_LAST) begin
                  ph_q <= '0;
                  if (!sclk_q) begin
                     // Rising edge: sample the slave's bit
                     sclk_q <= 1'b1;
                     rx_q   <= {rx_q[126:0], miso};
                  end else begin
                     sclk_q <= 1'b0;
                     if (bit_q == 9'd127) begin
                        state_q <= S_CS_HOLD;
                     end else begin
                        bit_q <= bit_q + 9'd1;
                     end
                  end
               end else begin
                  ph_q <= ph_q + 8'd1;
               end
            end
            S_CS_HOLD: begin
               if (cmpl_d) begin
                  cs_q       <= 1'b1;
                  data_out_q <= rx_q;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end else begin
                  ph_q <= ph_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_out_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign CS       = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_aes_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_aes_master_ctrl
//  Purpose  : Self-checking bench for spi_aes_master_ctrl with an SPI slave
//             model that captures MOSI and returns a chosen 128-bit response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_aes_master_ctrl;

   localparam int CD = 2;
   localparam int GC = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         decrypt = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] data_in = '0;
   logic         busy, done, sclk, mosi, miso, CS;
   logic [127:0] data_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spi_aes_master_ctrl #(.CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .decrypt  (decrypt),
      .key      (key),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .data_out (data_out),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
      .CS       (CS)
   );

   task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- SPI slave model (mode 0) ----------------
   logic [127:0] resp = '0;
   logic [263:0] cap = '0;
   int           n_rise = 0;
   int           out_len = 264;

   always @(negedge CS) begin
      cap     = '0;
      n_rise  = 0;
      out_len = 264;
   end

   always @(posedge sclk) begin
      if (!CS) begin
         if (n_rise < out_len) begin
            cap = {cap[262:0], mosi};
            if (n_rise == 7) out_len = cap[1] ? 264 : 136;
         end
         n_rise++;
      end
   end

   assign miso = (n_rise >= out_len && n_rise < out_len + 128) ? resp[127 - (n_rise - out_len)] : 1'b0;

   // ---------------- line monitor ----------------
   int   cs_low_cnt = 0;
   int   done_cnt = 0;
   int   cs_fall_cnt = 0;
   logic cs_prev = 1'b1;

   always @(negedge clk) begin
      if (CS === 1'b0) cs_low_cnt++;
      if (done === 1'b1) done_cnt++;
      if (cs_prev === 1'b1 && CS === 1'b0) cs_fall_cnt++;
      cs_prev = CS;
   end

   // ---------------- reference model ----------------
   logic [127:0] m_last_key = '0;
   bit           m_vld = 1'b0;

   function automatic bit key_skip(input logic [127:0] k);
`ifdef SPI_CTRL_KEY_REUSE_EN
      return m_vld && (k == m_last_key);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic run_txn(input logic [127:0] k, input logic [127:0] d, input logic dec,
                          input logic [127:0] r, input bit spam);
      bit           skip;
      int           n;
      int           exp_len;
      logic [7:0]   cmd;
      logic [263:0] exp_frame;
      bit           seen;
      skip      = key_skip(k);
      n         = skip ? 136 : 264;
      cmd       = {6'b101001, !skip, dec};
      exp_frame = skip ? {128'd0, cmd, d} : {cmd, k, d};
      exp_len   = n * 2 * CD + GC + 128 * 2 * CD + CD;
      resp      = r;
      @(negedge clk);
      cs_low_cnt  = 0;
      done_cnt    = 0;
      cs_fall_cnt = 0;
      key = k; data_in = d; decrypt = dec; start = 1'b1;
      @(negedge clk);
      check("busy_after_start", 264'(busy), 264'(1'b1));
      check("cs_after_start", 264'(CS), 264'(1'b0));
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < exp_len + 50; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         start = spam;
         if (spam) begin
            key = rnd128(); data_in = rnd128(); decrypt = $urandom_range(0, 1);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_seen", 264'(seen), 264'(1'b1));
      check("data_out", 264'(data_out), 264'(r));
      check("cs_at_done", 264'(CS), 264'(1'b1));
      check("busy_at_done", 264'(busy), 264'(1'b0));
      repeat (3) @(negedge clk);
      check("cs_low_cycles", 264'(cs_low_cnt), 264'(exp_len));
      check("done_pulses", 264'(done_cnt), 264'(1));
      check("cs_low_periods", 264'(cs_fall_cnt), 264'(1));
      check("cmd_byte", 264'(skip ? cap[135:128] : cap[263:256]), 264'(cmd));
      check("mosi_frame", cap, exp_frame);
      check("sclk_rises", 264'(n_rise), 264'(n + 128));
      check("data_out_held", 264'(data_out), 264'(r));
      m_last_key = k;
      m_vld      = 1'b1;
   endtask

   task automatic abort_txn(input logic [127:0] k, input logic [127:0] d);
      @(negedge clk);
      done_cnt = 0;
      key = k; data_in = d; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (499) @(negedge clk);
      check("abort_cs_low_before", 264'(CS), 264'(1'b0));
      reset = 1'b1;
      #1;
      check("abort_cs", 264'(CS), 264'(1'b1));
      check("abort_sclk", 264'(sclk), 264'(1'b0));
      check("abort_mosi", 264'(mosi), 264'(1'b0));
      check("abort_busy", 264'(busy), 264'(1'b0));
      check("abort_data_out", 264'(data_out), 264'(0));
      check("abort_done", 264'(done), 264'(1'b0));
      @(negedge clk);
      reset = 1'b0;
      m_vld = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_no_done", 264'(done_cnt), 264'(0));
   endtask

   initial begin
      logic [127:0] k0, d0, r0, kr;
      k0 = 128'h000102030405060708090A0B0C0D0E0F;
      d0 = 128'h00112233445566778899AABBCCDDEEFF;
      r0 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

      repeat (3) @(negedge clk);
      check("rst_busy", 264'(busy), 264'(1'b0));
      check("rst_done", 264'(done), 264'(1'b0));
      check("rst_data_out", 264'(data_out), 264'(0));
      check("rst_sclk", 264'(sclk), 264'(1'b0));
      check("rst_mosi", 264'(mosi), 264'(1'b0));
      check("rst_cs", 264'(CS), 264'(1'b1));
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(k0, d0, 1'b0, r0, 1'b0);
      run_txn(k0, d0, 1'b1, ~r0, 1'b0);
      run_txn(k0, rnd128(), 1'b0, rnd128(), 1'b0);

      for (int i = 0; i < 3; i++) begin
         run_txn(rnd128(), rnd128(), 1'($urandom_range(0, 1)), rnd128(), 1'(i == 1));
      end

      kr = rnd128();
      run_txn(kr, rnd128(), 1'b0, rnd128(), 1'b0);
      run_txn(kr, rnd128(), 1'b1, rnd128(), 1'b1);

      abort_txn(kr, rnd128());
      run_txn(kr, rnd128(), 1'b0, rnd128(), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_aes_master_ctrl.md
# spi_aes_master_ctrl

SPI master-side controller that sequences one AES operation over the serial link to the SPI slave. It accepts a 128-bit key, a 128-bit data block and an encrypt/decrypt select from the host side. It serialises a command byte, the key and the block onto MOSI, waits a fixed turnaround gap, then shifts the 128-bit result back in from MISO. It generates SCLK and CS and hands the result to the host with a start/busy/done handshake.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 4: clk cycles of turnaround between the last MOSI bit and the first MISO bit; legal range 1..1023.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- decrypt  input  1  0 = encrypt, 1 = decrypt; captured with start.
- key  input  128  AES key; captured with start.
- data_in  input  128  plaintext/ciphertext block; captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when data_out is valid.
- data_out  output  128  received result; held until the next done.
- sclk  output  1  serial clock, idle low (SPI mode 0).
- mosi  output  1  master out, MSB first.
- miso  input  1  master in, sampled on the sclk rising edge.
- CS  output  1  active-low chip select; idle high.

## Operation
- States: IDLE, SHIFT_OUT, GAP, SHIFT_IN, CS_HOLD.
- IDLE with start=1: capture key, data_in and decrypt. Build the 8-bit command {6'b101001, key_present, decrypt}. Load the shift register with {cmd, key, data_in}, or {cmd, data_in} when the key is skipped. Bit count is 264 (136 when the key is skipped). Drive CS=0 and mosi=MSB. Enter SHIFT_OUT.
- The key is skipped only when SPI_CTRL_KEY_REUSE_EN is defined; see Configuration.
- Bit cell: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. On each sclk falling edge the register shifts left and mosi takes the next bit. The slave samples mosi on the rising edge.
- SHIFT_OUT ends at the falling edge after the last bit. mosi goes to 0 and the state becomes GAP.
- GAP: sclk low, CS low, for GAP_CYCLES cycles. Then enter SHIFT_IN.
- SHIFT_IN: 128 bit cells. On each sclk rising edge, miso shifts into the LSB of the receive register.
- After the last cell's high phase, sclk goes low and the state becomes CS_HOLD.
- CS_HOLD: CLK_DIV cycles with sclk low. Then CS=1, data_out gets the receive register, done=1 and busy=0, all in the same cycle. Return to IDLE.
- start while busy is ignored and not queued.
- Bit and phase counters wrap nowhere. Terminal counts are exact: 264/136, GAP_CYCLES, 128, CLK_DIV.

## Timing
- Reset values: busy=0, done=0, data_out=0, sclk=0, mosi=0, CS=1, state=IDLE. The key cache is cleared.
- Reset asserted mid-transfer aborts immediately: CS rises, sclk falls, and no done pulse is issued.
- CS is low for exactly N*2*CLK_DIV + GAP_CYCLES + 128*2*CLK_DIV + CLK_DIV clk cycles, with N = 264 or 136.
  - Defaults, N=264: 1574 cycles.
  - Defaults, N=136: 1062 cycles.
- start accepted at edge t gives CS=0 and busy=1 after edge t. done is high after edge t+1574 (default, full frame).
- start is accepted again on the cycle done is high (state is IDLE).

## Configuration
- SPI_CTRL_KEY_REUSE_EN
  - Defined: a 128-bit last-key register plus a valid flag are kept, updated when each transfer completes (done). If the captured key equals the last key and the flag is set, key_present=0 and the 128 key bits are omitted.
  - Not defined: key_present is always 1, every frame is 264 bits, and no cache is built.
  - Either way, reset clears the cache.

## Test plan
- Defaults, key=000102…0F, data_in=00112233…FF, decrypt=0, slave model echoes 128'hDEADBEEF_… → first 8 MOSI bits are 0xA6; CS low for 1574 cycles; done pulse; data_out equals the echoed value.
- decrypt=1 with the same inputs → command byte 0xA7; 264 MOSI bits match {0xA7, key, data_in} MSB first.
- SPI_CTRL_KEY_REUSE_EN defined, two back-to-back starts with the same key → second command is 0xA4; 136 bits sent; CS low 1062 cycles. A third start with a different key gets full 264 bits.
- start pulsed every cycle during a transfer → exactly one done, and no extra CS low period.
- reset asserted 500 cycles into a transfer → CS=1, sclk=0, mosi=0, busy=0, data_out=0 in the same cycle, no done. A subsequent start sends a full 264-bit frame even with the same key.
- CLK_DIV=1, GAP_CYCLES=1 → sclk period of 2 clk cycles; CS low 264*2+1+256+1 = 786 cycles; data_out correct.
